result_sram_reader: RTL and testbench

//  Streams the upscaled image back out of ResultSRAM after the Bicubic engine asserts DONE.

---
 rtl/bicubic_pkg.sv | 22 ++
 rtl/rd_tag_fifo.sv | 73 +++++++
 rtl/result_sram_reader.sv | 205 ++++++++++++++++++++
 tb/tb_result_sram_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants and types for the result SRAM read path.
package bicubic_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_e;

  // One buffered pixel together with its raster position marks.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eol;
    logic              eof;
  } pix_tag_t;

endpackage

// File: rtl/rd_tag_fifo.sv
// Small synchronous FIFO of pixel tags with a fall-through registered head.
module rd_tag_fifo
  import bicubic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pix_tag_t         push_data,
  input  logic             pop,
  output pix_tag_t         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pix_tag_t         mem_q [DEPTH];
  pix_tag_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer, count and storage next-state; a pop of an empty FIFO is dropped.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset also clears the head so PIX reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The reader's credit scheme must never let a capture land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/result_sram_reader.sv
// Streams a TW x TH image out of ResultSRAM in raster order on a valid/ready
// pixel stream with end-of-line / end-of-frame marks.
//
// Handshake: PIX, EOL and EOF are meaningful whenever PIX_VALID is high and
// stay unchanged until the cycle PIX_VALID & PIX_READY is seen at a rising
// edge, which is the single transfer point; PIX_VALID never drops without a
// transfer.
//
// Reads are launched from registered SRAM_A/SRAM_CEN. A read is only launched
// when reads in flight plus buffered pixels leave room in the FIFO, so the
// SRAM data returned RD_LAT cycles later always has a slot waiting for it.
module result_sram_reader
  import bicubic_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DIM_W-1:0]  TW,
  input  logic [DIM_W-1:0]  TH,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic              SRAM_CEN,
  input  logic [DATA_W-1:0] SRAM_Q,
  output logic [DATA_W-1:0] PIX,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              EOL,
  output logic              EOF,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output rd_state_e         DBG_STATE
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  tw_q, tw_d;
  logic [DIM_W-1:0]  th_q, th_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic              sram_cen_q, sram_cen_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_eol_q, tag_eol_d;
  logic [RD_LAT-1:0] tag_eof_q, tag_eof_d;

  logic              issue;
  logic              is_eol;
  logic              is_eof;
  logic              credit_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  pix_tag_t          fifo_head;
  pix_tag_t          fifo_in;

  assign fifo_push = tag_vld_q[RD_LAT-1];
  assign fifo_pop  = ~fifo_empty & PIX_READY;
  assign fifo_in   = '{data: SRAM_Q, eol: tag_eol_q[RD_LAT-1], eof: tag_eof_q[RD_LAT-1]};
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign is_eol    = (col_q == tw_q - DIM_W'(1));
  assign is_eof    = is_eol & (row_q == th_q - DIM_W'(1));

  // FSM next state, read issue, raster counters and tag pipeline.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    col_d      = col_q;
    row_d      = row_q;
    tw_d       = tw_q;
    th_d       = th_q;
    sram_a_d   = sram_a_q;
    sram_cen_d = 1'b1;
    issue      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          tw_d   = TW;
          th_d   = TH;
          addr_d = '0;
          col_d  = '0;
          row_d  = '0;
          last_d = ADDR_W'(TW) * ADDR_W'(TH) - ADDR_W'(1);
          // An empty frame skips straight to the completion pulse.
          state_d = ((TW == '0) || (TH == '0)) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue      = 1'b1;
          sram_cen_d = 1'b0;
          sram_a_d   = addr_q;
          addr_d     = addr_q + ADDR_W'(1);
          if (is_eol) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (addr_q == last_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Finish on the edge that hands over the final buffered pixel.
        if ((inflight_q == '0) &&
            (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tag_vld_d    = tag_vld_q;
    tag_eol_d    = tag_eol_q;
    tag_eof_d    = tag_eof_q;
    tag_vld_d[0] = issue;
    tag_eol_d[0] = issue & is_eol;
    tag_eof_d[0] = issue & is_eof;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_eol_d[i] = tag_eol_q[i-1];
      tag_eof_d[i] = tag_eof_q[i-1];
    end

    case ({issue, fifo_push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State, counters and registered SRAM controls; reset abandons any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      tw_q       <= '0;
      th_q       <= '0;
      inflight_q <= '0;
      sram_a_q   <= '0;
      sram_cen_q <= 1'b1;
      tag_vld_q  <= '0;
      tag_eol_q  <= '0;
      tag_eof_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tw_q       <= tw_d;
      th_q       <= th_d;
      inflight_q <= inflight_d;
      sram_a_q   <= sram_a_d;
      sram_cen_q <= sram_cen_d;
      tag_vld_q  <= tag_vld_d;
      tag_eol_q  <= tag_eol_d;
      tag_eof_q  <= tag_eof_d;
    end
  end

  rd_tag_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign SRAM_A     = sram_a_q;
  assign SRAM_CEN   = sram_cen_q;
  assign PIX        = fifo_head.data;
  assign EOL        = fifo_head.eol;
  assign EOF        = fifo_head.eof;
  assign PIX_VALID  = ~fifo_empty;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = (state_q == ST_FIN);
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_result_sram_reader.sv
// Bench for result_sram_reader: SRAM model on the falling edge, expected
// pixel/address queues filled at START, compared at each transfer/read.
module tb_result_sram_reader;
  import bicubic_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  tw, th;
  logic [ADDR_W-1:0] sram_a;
  logic              sram_cen;
  logic [DATA_W-1:0] sram_q = '0;
  logic [DATA_W-1:0] pix;
  logic              pix_valid;
  logic              pix_ready;
  logic              eol, eof, busy, frame_done;
  rd_state_e         dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  result_sram_reader dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .TW         (tw),
    .TH         (th),
    .SRAM_A     (sram_a),
    .SRAM_CEN   (sram_cen),
    .SRAM_Q     (sram_q),
    .PIX        (pix),
    .PIX_VALID  (pix_valid),
    .PIX_READY  (pix_ready),
    .EOL        (eol),
    .EOF        (eof),
    .BUSY       (busy),
    .FRAME_DONE (frame_done),
    .DBG_STATE  (dbg_state)
  );

  // SRAM contents are a fixed scramble of the address.
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] t;
    t = (a * 14'd37) ^ (a >> 5);
    return t[DATA_W-1:0];
  endfunction

  // ResultSRAM model, clocked on the inverted clock, one cycle read latency.
  always @(negedge clk) begin
    if (!sram_cen) sram_q <= mem_f(sram_a);
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W+1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int          n_issued = 0;
  int          n_xfer = 0;
  int          frame_xfers = 0;
  int          done_cnt = 0;
  int          last_evt_edge = 0;
  bit          frame_active = 0;
  bit          busy_chk = 0;
  bit          prev_stall = 0;
  logic [DATA_W+1:0] prev_word = '0;
  logic [DATA_W+1:0] exp_word;
  logic [ADDR_W-1:0] exp_addr;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      busy_chk   = 0;
      n_issued   = 0;
      n_xfer     = 0;
    end else begin
      if (!sram_cen) begin
        check_eq("credit", (n_issued + 1 - n_xfer) <= 4, 1);
        n_issued++;
        check_eq("addr_pending", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          exp_addr = addr_q.pop_front();
          check_eq("addr", sram_a, exp_addr);
        end
      end
      if (prev_stall) check_eq("hold", {pix_valid, eof, eol, pix}, {1'b1, prev_word});
      if (pix_valid && pix_ready) begin
        check_eq("pix_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_eq("pix", {eof, eol, pix}, exp_word);
        end
        n_xfer++;
        frame_xfers++;
        last_evt_edge = cyc + 1;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_word  = {eof, eol, pix};
      if (frame_done) begin
        check_eq("done_expected", frame_active, 1);
        check_eq("done_gap", cyc, last_evt_edge);
        check_eq("done_drained", exp_q.size(), 0);
        frame_active = 0;
        busy_chk = 1;
        done_cnt++;
      end else if (busy_chk) begin
        check_eq("busy_after_done", busy, 0);
        busy_chk = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       pix_ready = 1'($urandom_range(0, 1));
        2:       pix_ready = 1'b0;
        default: pix_ready = 1'b1;
      endcase
    end
  end

  task automatic start_frame(input int w, input int h);
    @(posedge clk);
    #1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        logic [ADDR_W-1:0] a;
        logic e_l, e_f;
        a   = ADDR_W'(r * w + c);
        e_l = (c == w - 1);
        e_f = e_l && (r == h - 1);
        exp_q.push_back({e_f, e_l, mem_f(a)});
        addr_q.push_back(a);
      end
    end
    tw            = DIM_W'(w);
    th            = DIM_W'(h);
    start         = 1'b1;
    frame_active  = 1;
    frame_xfers   = 0;
    last_evt_edge = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // START while busy, with different dimensions; must be ignored.
  task automatic poke_start();
    @(posedge clk);
    #1;
    tw    = DIM_W'($urandom_range(1, 63));
    th    = DIM_W'($urandom_range(1, 63));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    check_eq("frame_done_seen", done_cnt != d0, 1);
    check_eq("addr_all_issued", addr_q.size(), 0);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (frame_xfers >= n) break;
    end
    check_eq("xfer_reached", frame_xfers >= n, 1);
  endtask

  task automatic check_reset();
    check_eq("rst_sram_a", sram_a, 0);
    check_eq("rst_sram_cen", sram_cen, 1);
    check_eq("rst_pix", pix, 0);
    check_eq("rst_pix_valid", pix_valid, 0);
    check_eq("rst_eol", eol, 0);
    check_eq("rst_eof", eof, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tw    = '0;
    th    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // 1) 4x3 with sink always ready
    ready_mode = 0;
    start_frame(4, 3);
    wait_done(200);

    // 2) 8x2 with a six-cycle stall mid-frame
    start_frame(8, 2);
    wait_xfers(3, 100);
    ready_mode = 2;
    repeat (6) @(posedge clk);
    ready_mode = 0;
    wait_done(200);

    // 3) 1x1
    start_frame(1, 1);
    wait_done(50);

    // 4) zero width: no reads, immediate completion
    start_frame(0, 5);
    wait_done(20);

    // 5) reset after the fifth transfer of a 4x4 frame, then restart
    start_frame(4, 4);
    wait_xfers(5, 100);
    #1;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    frame_active = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    start_frame(4, 4);
    wait_done(200);

    // 6) 63x63 with random ready and spurious STARTs while busy
    ready_mode = 1;
    start_frame(63, 63);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(100, 1500)) @(posedge clk);
      poke_start();
    end
    wait_done(30000);
    ready_mode = 0;
    check_eq("big_frame_xfers", frame_xfers, 3969);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
